ps2_rx_controller: RTL and testbench

PS2_RX_CONTROLLER -- requirements
Module: ps2_rx_controller

---
 rtl/ps2_rx_controller.sv | 189 ++++++++++++++++++
 tb/tb_ps2_rx_controller.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_controller.sv
// PS/2 device-to-host receiver.
// Synchronizes the PS/2 clock and data lines, detects falling clock edges,
// assembles 11-bit frames (start, 8 data bits LSB-first, odd parity, stop),
// validates them and hands good scan bytes to a consumer through a
// one-entry data/data_valid holding register with overrun detection.
module ps2_rx_controller #(
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        rd_ready,
  output logic [7:0]  data,
  output logic        data_valid,
  output logic [10:0] frame_out,
  output logic        busy,
  output logic        frame_error,
  output logic        parity_error,
  output logic        overrun
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_ONE = TO_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_t;

  // Synchronizer chains and edge-detect history.
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   prev_clk_q;

  // Receiver state.
  state_t          state_q;
  logic [3:0]      bit_cnt_q;
  logic [10:0]     shift_q;
  logic [TO_W-1:0] to_cnt_q;

  // Registered outputs.
  logic [7:0]  data_q;
  logic        data_valid_q;
  logic [10:0] frame_out_q;
  logic        busy_q;
  logic        frame_error_q;
  logic        parity_error_q;
  logic        overrun_q;

  // Decoded signals.
  logic ps2_clk_s;
  logic ps2_data_s;
  logic edge_evt;
  logic stop_bad;
  logic parity_bad;

  // Bring both PS/2 lines into the clk domain; idle level of the bus is 1.
  always_ff @(posedge clk) begin
    // NOTE: every clocked assignment is non-blocking so that all registers
    // sample their inputs from the same edge and simulation matches hardware.
    if (reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      prev_clk_q  <= 1'b1;
    end else begin
      clk_sync_q[0]  <= ps2_clk;
      data_sync_q[0] <= ps2_data;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        clk_sync_q[i]  <= clk_sync_q[i-1];
        data_sync_q[i] <= data_sync_q[i-1];
      end
      prev_clk_q <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign ps2_clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign ps2_data_s = data_sync_q[SYNC_STAGES-1];

  // Falling-edge detection and frame validity decode from the shift register.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no
    // path can leave it unassigned and infer a latch.
    edge_evt   = 1'b0;
    stop_bad   = 1'b0;
    parity_bad = 1'b0;
    edge_evt   = prev_clk_q & ~ps2_clk_s;
    stop_bad   = ~shift_q[10];
    // Odd parity: data plus parity bit must hold an odd number of ones.
    parity_bad = ~(^shift_q[9:1]);
  end

  // Receiver FSM with registered outputs, holding register and flag pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      bit_cnt_q      <= 4'd0;
      shift_q        <= 11'h7FF;
      to_cnt_q       <= '0;
      data_q         <= 8'h00;
      data_valid_q   <= 1'b0;
      frame_out_q    <= 11'h7FF;
      busy_q         <= 1'b0;
      frame_error_q  <= 1'b0;
      parity_error_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      // Flags are single-cycle pulses unless re-asserted below.
      frame_error_q  <= 1'b0;
      parity_error_q <= 1'b0;
      overrun_q      <= 1'b0;

      // Consumer handshake; a reload in CHECK overrides this clear.
      if (data_valid_q && rd_ready) begin
        data_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          to_cnt_q <= '0;
          // A high data bit on a falling edge is line noise, not a start bit.
          if (edge_evt && !ps2_data_s) begin
            shift_q[0] <= 1'b0;
            bit_cnt_q  <= 4'd1;
            state_q    <= RECV;
            busy_q     <= 1'b1;
          end
        end

        RECV: begin
          if (edge_evt) begin
            shift_q[bit_cnt_q] <= ps2_data_s;
            to_cnt_q           <= '0;
            if (bit_cnt_q == 4'd10) begin
              bit_cnt_q <= 4'd0;
              state_q   <= CHECK;
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end else if (to_cnt_q == TO_MAX) begin
            // Device stopped clocking mid-frame: drop the partial frame.
            frame_error_q <= 1'b1;
            bit_cnt_q     <= 4'd0;
            to_cnt_q      <= '0;
            state_q       <= IDLE;
            busy_q        <= 1'b0;
          end else begin
            to_cnt_q <= to_cnt_q + TO_ONE;
          end
        end

        CHECK: begin
          // Edge events here are ignored; the line is between frames.
          frame_out_q <= shift_q;
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          if (stop_bad) begin
            frame_error_q <= 1'b1;
          end else if (parity_bad) begin
            parity_error_q <= 1'b1;
          end else if (!data_valid_q || rd_ready) begin
            data_q       <= shift_q[8:1];
            data_valid_q <= 1'b1;
          end else begin
            overrun_q <= 1'b1;
          end
        end

        default: begin
          state_q   <= IDLE;
          bit_cnt_q <= 4'd0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign data         = data_q;
  assign data_valid   = data_valid_q;
  assign frame_out    = frame_out_q;
  assign busy         = busy_q;
  assign frame_error  = frame_error_q;
  assign parity_error = parity_error_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_ps2_rx_controller.sv
// Directed bench for ps2_rx_controller: a table of whole frames with
// hand-computed results, plus hand-written sequences for latency, timeout,
// overrun, mid-frame reset and idle noise.
module tb_ps2_rx_controller;

  localparam int TIMEOUT_CYCLES = 60;
  localparam int SYNC_STAGES    = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic        rd_ready = 1'b0;
  logic [7:0]  data;
  logic        data_valid;
  logic [10:0] frame_out;
  logic        busy;
  logic        frame_error;
  logic        parity_error;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int pe_cnt = 0;
  int ov_cnt = 0;

  ps2_rx_controller #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .rd_ready    (rd_ready),
    .data        (data),
    .data_valid  (data_valid),
    .frame_out   (frame_out),
    .busy        (busy),
    .frame_error (frame_error),
    .parity_error(parity_error),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (frame_error === 1'b1)  fe_cnt++;
    if (parity_error === 1'b1) pe_cnt++;
    if (overrun === 1'b1)      ov_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic par, input logic stop);
    return {stop, par, b, 1'b0};
  endfunction

  task automatic send_bit(input logic b);
    @(negedge clk) ps2_data = b;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (8) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) send_bit(f[i]);
  endtask

  // Full frame; the last bit is driven by hand so rd_ready can be placed in
  // the CHECK cycle and the 2-cycle output latency can be observed.
  task automatic send_frame(input logic [10:0] f, input logic rd_in_check,
                            input logic lat_chk, input logic [7:0] exp_byte);
    send_bits(f, 10);
    @(negedge clk) ps2_data = f[10];
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
    // Two posedges to synchronize, one to leave RECV: now in CHECK.
    repeat (3) @(posedge clk);
    #1;
    if (lat_chk) begin
      check("lat_busy_in_check", busy, 1);
      check("lat_dv_not_yet", data_valid, 0);
      check("lat_fo_not_yet", frame_out, 11'h7FF);
    end
    @(negedge clk) rd_ready = rd_in_check;
    @(posedge clk);
    #1;
    if (lat_chk) begin
      check("lat_dv", data_valid, 1);
      check("lat_data", data, exp_byte);
      check("lat_fo", frame_out, f);
      check("lat_busy_done", busy, 0);
    end
    @(negedge clk) rd_ready = 1'b0;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic consume();
    @(negedge clk) rd_ready = 1'b1;
    @(negedge clk) rd_ready = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  b;
    logic        par;
    logic        stop;
    logic        pre_consume;
    logic [7:0]  exp_data;
    logic        exp_dv;
    logic [10:0] exp_fo;
    int          exp_fe;
    int          exp_pe;
    int          exp_ov;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int fe0, pe0, ov0, waited;

    vecs[0] = '{8'h1C, 1'b1, 1'b1, 1'b0, 8'h1C, 1'b0, 11'h638, 0, 1, 0};
    vecs[1] = '{8'h1C, 1'b0, 1'b0, 1'b0, 8'h1C, 1'b0, 11'h038, 1, 0, 0};
    vecs[2] = '{8'hF0, 1'b1, 1'b1, 1'b0, 8'hF0, 1'b1, 11'h7E0, 0, 0, 0};
    vecs[3] = '{8'h1C, 1'b0, 1'b1, 1'b0, 8'hF0, 1'b1, 11'h438, 0, 0, 1};
    vecs[4] = '{8'h1C, 1'b0, 1'b1, 1'b1, 8'h1C, 1'b1, 11'h438, 0, 0, 0};
    vecs[5] = '{8'h55, 1'b1, 1'b1, 1'b1, 8'h55, 1'b1, 11'h6AA, 0, 0, 0};
    vecs[6] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 11'h600, 0, 0, 0};
    vecs[7] = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 11'h7FE, 0, 0, 0};
    vecs[8] = '{8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 11'h5FE, 0, 1, 0};

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_data", data, 8'h00);
    check("rst_dv", data_valid, 0);
    check("rst_fo", frame_out, 11'h7FF);
    check("rst_busy", busy, 0);
    check("rst_flags", {frame_error, parity_error, overrun}, 3'b000);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Good 0x1C frame with latency check, then consume.
    send_frame(mk_frame(8'h1C, 1'b0, 1'b1), 1'b0, 1'b1, 8'h1C);
    check("first_fo", frame_out, 11'h438);
    check("first_flags", fe_cnt + pe_cnt + ov_cnt, 0);
    consume();
    @(negedge clk);
    check("consume_dv", data_valid, 0);
    check("consume_data_kept", data, 8'h1C);

    // Table of whole frames.
    for (int i = 0; i < 9; i++) begin
      fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
      if (vecs[i].pre_consume) consume();
      send_frame(mk_frame(vecs[i].b, vecs[i].par, vecs[i].stop), 1'b0, 1'b0, 8'h00);
      repeat (4) @(negedge clk);
      check($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
      check($sformatf("vec%0d_dv", i), data_valid, vecs[i].exp_dv);
      check($sformatf("vec%0d_fo", i), frame_out, vecs[i].exp_fo);
      check($sformatf("vec%0d_fe", i), fe_cnt - fe0, vecs[i].exp_fe);
      check($sformatf("vec%0d_pe", i), pe_cnt - pe0, vecs[i].exp_pe);
      check($sformatf("vec%0d_ov", i), ov_cnt - ov0, vecs[i].exp_ov);
      check($sformatf("vec%0d_busy", i), busy, 0);
    end

    // Timeout after 5 bits.
    fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
    send_bits(mk_frame(8'hF0, 1'b1, 1'b1), 5);
    check("to_busy_recv", busy, 1);
    waited = 0;
    for (int i = 0; i < TIMEOUT_CYCLES + 40; i++) begin
      if (fe_cnt != fe0) break;
      @(negedge clk);
      waited++;
    end
    check("to_fe_pulse", fe_cnt - fe0, 1);
    check("to_not_early", waited >= TIMEOUT_CYCLES - 20, 1);
    repeat (3) @(negedge clk);
    check("to_busy_idle", busy, 0);
    check("to_fo_unchanged", frame_out, 11'h5FE);
    check("to_other_flags", (pe_cnt - pe0) + (ov_cnt - ov0), 0);
    send_frame(mk_frame(8'hF0, 1'b1, 1'b1), 1'b0, 1'b0, 8'h00);
    repeat (4) @(negedge clk);
    check("to_next_data", data, 8'hF0);
    check("to_next_dv", data_valid, 1);

    // Overrun, then rd_ready in the CHECK cycle.
    ov0 = ov_cnt;
    send_frame(mk_frame(8'h1C, 1'b0, 1'b1), 1'b0, 1'b0, 8'h00);
    repeat (4) @(negedge clk);
    check("ovr_pulse", ov_cnt - ov0, 1);
    check("ovr_data_kept", data, 8'hF0);
    check("ovr_dv", data_valid, 1);
    ov0 = ov_cnt;
    send_frame(mk_frame(8'h1C, 1'b0, 1'b1), 1'b1, 1'b0, 8'h00);
    repeat (4) @(negedge clk);
    check("rdchk_no_ovr", ov_cnt - ov0, 0);
    check("rdchk_data", data, 8'h1C);
    check("rdchk_dv", data_valid, 1);

    // Reset after 6 bits.
    fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
    send_bits(mk_frame(8'hF0, 1'b1, 1'b1), 6);
    check("mid_busy_before", busy, 1);
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ps2_data = 1'b1;
    @(negedge clk);
    check("mid_busy", busy, 0);
    check("mid_dv", data_valid, 0);
    check("mid_fo", frame_out, 11'h7FF);
    repeat (TIMEOUT_CYCLES + 20) @(negedge clk);
    check("mid_no_flags", (fe_cnt - fe0) + (pe_cnt - pe0) + (ov_cnt - ov0), 0);
    send_frame(mk_frame(8'h1C, 1'b0, 1'b1), 1'b0, 1'b0, 8'h00);
    repeat (4) @(negedge clk);
    check("mid_next_data", data, 8'h1C);
    check("mid_next_dv", data_valid, 1);
    check("mid_next_fo", frame_out, 11'h438);

    // Falling edges with data high while idle.
    fe0 = fe_cnt; pe0 = pe_cnt; ov0 = ov_cnt;
    for (int i = 0; i < 3; i++) begin
      send_bit(1'b1);
      check($sformatf("idle_noise%0d_busy", i), busy, 0);
    end
    repeat (TIMEOUT_CYCLES + 10) @(negedge clk);
    check("idle_noise_flags", (fe_cnt - fe0) + (pe_cnt - pe0) + (ov_cnt - ov0), 0);
    check("idle_noise_fo", frame_out, 11'h438);
    check("idle_noise_data", data, 8'h1C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
